// File: rtl/x_stretch_pkg.sv
// Shared types and default sizes for the x_stretch pulse stretcher.
package x_stretch_pkg;

    localparam int unsigned MXW_DEF   = 4;
    localparam int unsigned MXH_DEF   = 4;
    localparam int unsigned MXCNT_DEF = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        HOLDOFF = 2'd2
    } stretch_state_t;

endpackage

// File: rtl/x_sat_counter.sv
// Saturating event counter; a synchronous clear beats a same-cycle increment.
module x_sat_counter
    import x_stretch_pkg::*;
#(
    parameter int unsigned MXCNT = MXCNT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [MXCNT-1:0] cnt
);

    logic [MXCNT-1:0] cnt_q;
    logic [MXCNT-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + MXCNT'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/x_stretch.sv
// Pulse stretcher with holdoff and accept/reject accounting.
// Define X_STRETCH_RETRIG_EN to let edges during STRETCH extend the pulse.
module x_stretch
    import x_stretch_pkg::*;
#(
    parameter int unsigned MXW   = MXW_DEF,
    parameter int unsigned MXH   = MXH_DEF,
    parameter int unsigned MXCNT = MXCNT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             d,
    input  logic [MXW-1:0]   width,
    input  logic [MXH-1:0]   holdoff,
    input  logic             cnt_clr,
    output logic             q,
    output logic             busy,
    output logic [MXCNT-1:0] n_accept,
    output logic [MXCNT-1:0] n_reject
);

`ifdef X_STRETCH_RETRIG_EN
    localparam logic RETRIG_EN = 1'b1;
`else
    localparam logic RETRIG_EN = 1'b0;
`endif

    stretch_state_t state_q, state_d;
    logic           d_prev_q, d_prev_d;
    logic           arm_q, arm_d;
    logic           edge_q, edge_d;
    logic [MXW-1:0] wcnt_q, wcnt_d;
    logic [MXH-1:0] hcnt_q, hcnt_d;
    logic           q_q, q_d;
    logic           busy_q, busy_d;
    logic           accept_c;
    logic           reject_c;
    logic [MXW-1:0] wload_c;

    assign wload_c = (width == '0) ? MXW'(1) : width;

    // First sample after reset only primes d_prev, so a level already high is not an edge.
    always_comb begin
        d_prev_d = d;
        arm_d    = 1'b1;
        edge_d   = d & ~d_prev_q & arm_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            d_prev_q <= 1'b0;
            arm_q    <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_prev_q <= d_prev_d;
            arm_q    <= arm_d;
            edge_q   <= edge_d;
        end
    end

    // The exit cycle of STRETCH (no holdoff) or HOLDOFF can take a new edge directly.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        reject_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_q) begin
                    state_d  = STRETCH;
                    accept_c = 1'b1;
                end
            end
            STRETCH: begin
                if (edge_q && (RETRIG_EN || ((wcnt_q == MXW'(1)) && (holdoff == '0)))) begin
                    accept_c = 1'b1;
                end else begin
                    reject_c = edge_q;
                    if (wcnt_q == MXW'(1)) begin
                        state_d = (holdoff != '0) ? HOLDOFF : IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (hcnt_q == MXH'(1)) begin
                    if (edge_q) begin
                        state_d  = STRETCH;
                        accept_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    reject_c = edge_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wcnt_d = wcnt_q;
        hcnt_d = hcnt_q;
        if (accept_c) begin
            wcnt_d = wload_c;
        end else if (state_q == STRETCH) begin
            wcnt_d = wcnt_q - MXW'(1);
        end
        if ((state_q == STRETCH) && (state_d == HOLDOFF)) begin
            hcnt_d = holdoff;
        end else if (state_q == HOLDOFF) begin
            hcnt_d = hcnt_q - MXH'(1);
        end
        q_d    = (state_d == STRETCH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q <= '0;
            hcnt_q <= '0;
            q_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            hcnt_q <= hcnt_d;
            q_q    <= q_d;
            busy_q <= busy_d;
        end
    end

    assign q    = q_q;
    assign busy = busy_q;

    x_sat_counter #(.MXCNT(MXCNT)) u_acc_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (accept_c),
        .clr     (cnt_clr),
        .cnt     (n_accept)
    );

    x_sat_counter #(.MXCNT(MXCNT)) u_rej_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (reject_c),
        .clr     (cnt_clr),
        .cnt     (n_reject)
    );

endmodule

// File: tb/tb_x_stretch.sv
// Scoreboard bench for x_stretch: event-window reference model feeds a queue checked every cycle.
module tb_x_stretch;

    localparam int unsigned TB_MXCNT = 3;
    localparam int CMAX = (1 << TB_MXCNT) - 1;
`ifdef X_STRETCH_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic       d;
    logic [3:0] width;
    logic [3:0] holdoff;
    logic       cnt_clr;
    logic       q;
    logic       busy;
    logic [2:0] n_accept;
    logic [2:0] n_reject;

    always #5 clock = ~clock;

    x_stretch #(.MXW(4), .MXH(4), .MXCNT(TB_MXCNT)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .d        (d),
        .width    (width),
        .holdoff  (holdoff),
        .cnt_clr  (cnt_clr),
        .q        (q),
        .busy     (busy),
        .n_accept (n_accept),
        .n_reject (n_reject)
    );

    typedef struct packed {
        logic       q;
        logic       busy;
        logic [2:0] na;
        logic [2:0] nr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Reference state: clock-edge index, last accepted edge and its window, counts.
    int j       = 0;
    int e_last  = -1000;
    int w_last  = 1;
    int h_last  = 0;
    int acc_n   = 0;
    int rej_n   = 0;
    bit pend    = 1'b0;
    bit prev_d  = 1'b0;
    bit prev_ok = 1'b0;

    function automatic void model_reset();
        e_last  = j - 1000;
        w_last  = 1;
        h_last  = 0;
        acc_n   = 0;
        rej_n   = 0;
        pend    = 1'b0;
        prev_d  = 1'b0;
        prev_ok = 1'b0;
    endfunction

    // A rising edge sampled at edge k is decided at k+1; an accepted edge at e owns
    // q over [e, e+W-1] and busy over [e, e+W+H-1]; the next edge is free at e+W+H.
    function automatic void model_step();
        exp_t e;
        bit   inc_a = 1'b0;
        bit   inc_r = 1'b0;
        int   w;
        j = j + 1;
        if (pend) begin
            w = (width == 4'd0) ? 1 : int'(width);
            if ((j - e_last >= w_last + h_last) || (RETRIG && (j - e_last <= w_last))) begin
                e_last = j;
                w_last = w;
                h_last = int'(holdoff);
                inc_a  = 1'b1;
            end else begin
                inc_r = 1'b1;
            end
        end
        if (cnt_clr) begin
            acc_n = 0;
            rej_n = 0;
        end else begin
            if (inc_a && acc_n < CMAX) acc_n = acc_n + 1;
            if (inc_r && rej_n < CMAX) rej_n = rej_n + 1;
        end
        pend    = prev_ok && d && !prev_d;
        prev_d  = d;
        prev_ok = 1'b1;
        e.q    = (j >= e_last) && (j <= e_last + w_last - 1);
        e.busy = (j >= e_last) && (j <= e_last + w_last + h_last - 1);
        e.na   = 3'(acc_n);
        e.nr   = 3'(rej_n);
        sb.push_back(e);
    endfunction

    task automatic cyc(input logic dv, input logic clr);
        d       = dv;
        cnt_clr = clr;
        @(posedge clock);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic run(input logic dv, input int n);
        repeat (n) cyc(dv, 1'b0);
    endtask

    // Stimulus
    initial begin
        int   dens;
        logic dv;
        reset_n = 1'b0;
        d       = 1'b0;
        width   = 4'd3;
        holdoff = 4'd0;
        cnt_clr = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();

        // basic pulse
        run(1'b0, 9);
        run(1'b1, 1);
        run(1'b0, 10);

        // width zero, then a long level
        cyc(1'b0, 1'b1);
        width = 4'd0;
        run(1'b1, 1);
        run(1'b0, 5);
        cyc(1'b0, 1'b1);
        run(1'b1, 20);
        run(1'b0, 10);

        // holdoff reject then accept at +7
        cyc(1'b0, 1'b1);
        width   = 4'd2;
        holdoff = 4'd4;
        run(1'b1, 1); run(1'b0, 2);
        run(1'b1, 1); run(1'b0, 3);
        run(1'b1, 1); run(1'b0, 15);

        // edge during STRETCH
        cyc(1'b0, 1'b1);
        width   = 4'd4;
        holdoff = 4'd0;
        run(1'b1, 1); run(1'b0, 1);
        run(1'b1, 1); run(1'b0, 15);

        // saturation, then clear coincident with the 10th accepted edge
        cyc(1'b0, 1'b1);
        width = 4'd1;
        repeat (9) begin
            run(1'b1, 1);
            run(1'b0, 1);
        end
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        run(1'b0, 5);

        // reset during STRETCH, then release with d already high
        width   = 4'd8;
        holdoff = 4'd3;
        run(1'b1, 1);
        run(1'b0, 3);
        d = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();
        run(1'b1, 6);
        run(1'b0, 2);
        run(1'b1, 3);
        run(1'b0, 20);

        // random phases; holdoff only changes once the block has been quiet
        for (int p = 0; p < 8; p++) begin
            run(1'b0, 40);
            holdoff = (p % 3 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            dens    = 1 + (p % 5);
            for (int k = 0; k < 300; k++) begin
                if ($urandom_range(0, 3) == 0) width = 4'($urandom_range(0, 15));
                dv = ($urandom_range(0, 7) < dens);
                cyc(dv, ($urandom_range(0, 31) == 0));
            end
        end
        run(1'b0, 5);
        done = 1'b1;
    end

    // Monitor: reset state while reset_n is low, scoreboard entry otherwise
    initial begin
        exp_t e;
        int   guard = 0;
        while (!done && guard < 50000) begin
            @(negedge clock);
            guard++;
            if (!reset_n) begin
                if (sb.size() > 0) e = sb.pop_front();
                checks++;
                if ({q, busy, n_accept, n_reject} !== 8'h00) begin
                    errors++;
                    $display("FAIL reset t=%0t got q=%b busy=%b acc=%0d rej=%0d need all zero",
                             $time, q, busy, n_accept, n_reject);
                end
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({q, busy, n_accept, n_reject} !== e) begin
                    errors++;
                    $display("FAIL sb t=%0t got q=%b busy=%b acc=%0d rej=%0d need q=%b busy=%b acc=%0d rej=%0d",
                             $time, q, busy, n_accept, n_reject, e.q, e.busy, e.na, e.nr);
                end
            end
        end
        if (guard >= 50000) begin
            errors++;
            $display("FAIL watchdog got %0d cycles need stimulus end", guard);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending need 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
